sqrt_fifo_drain_stage: RTL and testbench

//  Downstream consumer of the sqrt-formula operand FIFO (show-ahead read, push/pop/empty/full).

---
 rtl/sqrt_fifo_drain_stage.sv | 124 ++++++++++++
 tb/tb_sqrt_fifo_drain_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_fifo_drain_stage.sv
// Drains operands from a show-ahead FIFO and computes floor(sqrt(x)) plus remainder,
// one root bit per cycle, presenting each result on a valid/ready interface.
module sqrt_fifo_drain_stage #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_read_data,
  output logic                 fifo_pop,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH/2-1:0]   res_root,
  output logic [WIDTH/2:0]     res_rem,
  output logic                 busy
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] op_sh_q, op_sh_d;
  logic [N+1:0]    rem_q,   rem_d;
  logic [N-1:0]    root_q,  root_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  // One digit-by-digit step: bring down the next operand bit pair, try root*4+1.
  logic [N+3:0]    rem_t;
  logic [N+3:0]    trial;
  logic            trial_ge;
  logic [N+1:0]    rem_diff;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = CALC;
      CALC: if (cnt_q == '0) state_d = DONE;
      DONE: if (res_ready)   state_d = fifo_empty ? IDLE : CALC;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: fifo_pop = !fifo_empty;
      CALC: busy     = 1'b1;
      DONE: begin
        res_valid = 1'b1;
        busy      = 1'b1;
        fifo_pop  = res_ready && !fifo_empty;
      end
      default: ;
    endcase
    // The pop strobe is combinational, so it must be gated by reset directly.
    if (rst) fifo_pop = 1'b0;
  end

  // Remainder stays below 2^(N+2), so the difference can be taken on N+2 bits;
  // the full-width compare still sees every bit of rem_q.
  assign rem_t    = {rem_q, op_sh_q[WIDTH-1 -: 2]};
  assign trial    = {2'b00, root_q, 2'b01};
  assign trial_ge = (rem_t >= trial);
  assign rem_diff = rem_t[N+1:0] - trial[N+1:0];

  always_comb begin
    op_sh_d = op_sh_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    if (fifo_pop) begin
      op_sh_d = fifo_read_data;
      rem_d   = '0;
      root_d  = '0;
      cnt_d   = CW'(N - 1);
    end else if (state_q == CALC) begin
      op_sh_d = op_sh_q << 2;
      rem_d   = trial_ge ? rem_diff : rem_t[N+1:0];
      root_d  = {root_q[N-2:0], trial_ge};
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: datapath registers are reset too, so the result outputs read zero
  // after reset and a half-finished operand never leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sh_q <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      op_sh_q <= op_sh_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  // Root and remainder are frozen in DONE until the handshake reloads them.
  assign res_root = root_q;
  assign res_rem  = rem_q[N:0];

endmodule

// File: tb/tb_sqrt_fifo_drain_stage.sv
// Self-checking bench for sqrt_fifo_drain_stage: FIFO model feeds operands,
// a scoreboard of reference-model sqrt results is compared at each handshake.
module tb_sqrt_fifo_drain_stage;

  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 2;

  typedef struct {
    logic [N-1:0] root;
    logic [N:0]   rem;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_read_data;
  logic             fifo_pop;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_root;
  logic [N:0]       res_rem;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] fq[$];
  exp_t             exp_q[$];
  int               pop_log[$];
  logic [WIDTH-1:0] popdata_log[$];
  int               rise_log[$];
  int               hs_log[$];
  logic             prev_valid = 1'b0;

  sqrt_fifo_drain_stage #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_pop       (fifo_pop),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_root       (res_root),
    .res_rem        (res_rem),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: bitwise search for the largest r with r*r <= x.
  function automatic exp_t model(input logic [WIDTH-1:0] x);
    exp_t   e;
    longint xx;
    longint r;
    longint t;
    longint d;
    xx = 64'(x);
    r  = 0;
    for (int b = N - 1; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= xx) r = t;
    end
    d      = xx - r * r;
    e.root = r[N-1:0];
    e.rem  = d[N:0];
    return e;
  endfunction

  // Show-ahead FIFO model: pop on the clock edge when the DUT strobes.
  always @(posedge clk) begin
    cyc++;
    if (fifo_pop && fq.size() > 0) void'(fq.pop_front());
    fifo_empty     <= (fq.size() == 0);
    fifo_read_data <= (fq.size() > 0) ? fq[0] : '0;
  end

  // Monitor: sampled mid-cycle, when inputs for the coming edge are settled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      n_assert++;
      if (fifo_pop && fifo_empty) begin
        n_fail++;
        $display("FAIL pop_while_empty cycle %0d: fifo_pop=1 with fifo_empty=1, required fifo_pop=0", cyc);
      end
    end
    if (fifo_pop) begin
      pop_log.push_back(cyc);
      popdata_log.push_back(fifo_read_data);
    end
    if (res_valid && !prev_valid) rise_log.push_back(cyc);
    prev_valid = res_valid;
    if (res_valid && res_ready) begin
      hs_log.push_back(cyc);
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result cycle %0d: root=%0h rem=%0h, required no result", cyc, res_root, res_rem);
      end else begin
        e = exp_q.pop_front();
        if (res_root !== e.root || res_rem !== e.rem) begin
          n_fail++;
          $display("FAIL result cycle %0d: root=%0h rem=%0h, required root=%0h rem=%0h",
                   cyc, res_root, res_rem, e.root, e.rem);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [WIDTH-1:0] x);
    fq.push_back(x);
    exp_q.push_back(model(x));
    fifo_empty     = 1'b0;
    fifo_read_data = fq[0];
  endtask

  task automatic clear_logs();
    pop_log.delete();
    popdata_log.delete();
    rise_log.delete();
    hs_log.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    n_assert++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s drain: pending=%0d busy=%b, required pending=0 busy=0", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    res_ready      = 1'b0;
    fifo_empty     = 1'b1;
    fifo_read_data = '0;
    repeat (3) step();
    push(32'h0);
    @(negedge clk);
    n_assert++;
    if (fifo_pop !== 1'b0 || res_valid !== 1'b0 || res_root !== '0 || res_rem !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pop=%b valid=%b root=%0h rem=%0h busy=%b, required all 0",
               fifo_pop, res_valid, res_root, res_rem, busy);
    end
  endtask

  task automatic test_zero_latency();
    clear_logs();
    step();
    res_ready = 1'b1;
    rst       = 1'b0;
    wait_drain("zero", 100);
    n_assert++;
    if (pop_log.size() < 1 || rise_log.size() < 1) begin
      n_fail++;
      $display("FAIL zero_latency: pops=%0d rises=%0d, required 1 and 1", pop_log.size(), rise_log.size());
    end else if (rise_log[0] - pop_log[0] !== 17) begin
      n_fail++;
      $display("FAIL zero_latency: %0d cycles, required 17", rise_log[0] - pop_log[0]);
    end
  endtask

  task automatic test_all_ones();
    step();
    push(32'hFFFF_FFFF);
    wait_drain("all_ones", 100);
  endtask

  task automatic test_back_to_back();
    clear_logs();
    step();
    res_ready = 1'b1;
    push(32'd1_000_000);
    push(32'd99);
    wait_drain("back_to_back", 150);
    n_assert++;
    if (hs_log.size() != 2 || pop_log.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_counts: handshakes=%0d pops=%0d, required 2 and 2", hs_log.size(), pop_log.size());
    end else begin
      n_assert++;
      if (pop_log[1] !== hs_log[0]) begin
        n_fail++;
        $display("FAIL b2b_pop_cycle: second pop cycle %0d, required %0d", pop_log[1], hs_log[0]);
      end
      n_assert++;
      if (hs_log[1] - hs_log[0] !== 17) begin
        n_fail++;
        $display("FAIL b2b_spacing: %0d cycles, required 17", hs_log[1] - hs_log[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int waited;
    step();
    res_ready = 1'b0;
    push(32'd36);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!res_valid && waited < 60);
    n_assert++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_valid_timeout: res_valid=%b, required 1", res_valid);
    end
    step();
    push(32'd49);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_assert++;
      if (res_valid !== 1'b1 || res_root !== 16'd6 || res_rem !== 17'd0 || fifo_pop !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid=%b root=%0d rem=%0d pop=%b busy=%b, required 1 6 0 0 1",
                 i, res_valid, res_root, res_rem, fifo_pop, busy);
      end
    end
    step();
    res_ready = 1'b1;
    wait_drain("backpressure", 100);
  endtask

  task automatic test_full_fifo();
    clear_logs();
    step();
    res_ready = 1'b1;
    push(32'd0);
    push(32'hFFFF_FFFF);
    push(32'd1);
    push(32'd2);
    push(32'hFFFE_0001);
    push(32'hFFFE_0000);
    push($urandom());
    push($urandom());
    wait_drain("full_fifo", 8 * 17 + 50);
    n_assert++;
    if (pop_log.size() != 8 || hs_log.size() != 8) begin
      n_fail++;
      $display("FAIL full_counts: pops=%0d handshakes=%0d, required 8 and 8", pop_log.size(), hs_log.size());
    end
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_idle: busy=%b valid=%b, required 0 0", busy, res_valid);
    end
  endtask

  task automatic test_random_ready();
    step();
    for (int i = 0; i < 5; i++) push($urandom());
    for (int i = 0; i < 800; i++) begin
      step();
      res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    step();
    res_ready = 1'b1;
    wait_drain("random_ready", 50);
  endtask

  task automatic test_reset_mid_calc();
    int waited;
    clear_logs();
    step();
    res_ready = 1'b1;
    push(32'h1234_5678);
    push(32'd144);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (pop_log.size() == 0 && waited < 10);
    n_assert++;
    if (pop_log.size() == 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_pop: pops=0, required 1");
    end
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_assert++;
      if (fifo_pop !== 1'b0 || res_valid !== 1'b0 || res_root !== '0 || res_rem !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_outputs: pop=%b valid=%b root=%0h rem=%0h busy=%b, required all 0",
                 fifo_pop, res_valid, res_root, res_rem, busy);
      end
    end
    clear_logs();
    step();
    rst = 1'b0;
    wait_drain("reset_mid", 100);
    n_assert++;
    if (popdata_log.size() != 1) begin
      n_fail++;
      $display("FAIL rst_mid_pops: pops=%0d, required 1", popdata_log.size());
    end else if (popdata_log[0] !== 32'd144) begin
      n_fail++;
      $display("FAIL rst_mid_head: popped %0d, required 144", popdata_log[0]);
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_all_ones();
    test_back_to_back();
    test_backpressure();
    test_full_fifo();
    test_random_ready();
    test_reset_mid_calc();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
